uart_slave: RTL

- Memory-mapped UART peripheral on the CPU data bus, in the 256-byte UART window decoded by the bus mux at 0x100000.
- Consumes the mux's slave-port bus: 8-bit address, 16-bit data, data strobe and ack.
- Provides 8N1 serial TX/RX with a runtime baud divisor and 16-entry TX and RX FIFOs.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/sync_fifo.sv | 60 ++++++
 rtl/uart_slave.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART.
//   - Register byte offsets inside the 256-byte UART window (bus_addr[0] ignored).
//   - STATUS register bit positions.
//   - Serial FSM state encoding shared by the TX and RX engines.
//   - Smallest usable baud divisor.
package uart_pkg;

  localparam logic [7:0] ADDR_DATA   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h02;
  localparam logic [7:0] ADDR_BAUD   = 8'h04;
  localparam logic [7:0] ADDR_CTRL   = 8'h06;

  localparam int STAT_RX_NOT_EMPTY = 0;
  localparam int STAT_RX_FULL      = 1;
  localparam int STAT_TX_EMPTY     = 2;
  localparam int STAT_TX_FULL      = 3;
  localparam int STAT_TX_BUSY      = 4;
  localparam int STAT_OVERRUN      = 5;

  localparam logic [15:0] MIN_DIV = 16'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO used for both UART directions.
//   clk, reset_n : clock, asynchronous active-low reset (pointers/count only)
//   push, din    : write request and data; dropped when full unless a pop
//                  happens in the same cycle
//   pop, dout    : read request; dout always shows the head entry
//   full, empty  : occupancy flags; count is the number of stored entries
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic [WIDTH-1:0]      din,
  input  logic                  pop,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A pop frees the slot the push needs, so both succeed on a full FIFO.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_slave.sv
// Memory-mapped 8N1 UART on the CPU data bus slave port.
//   clk, reset_n        : system clock, asynchronous active-low reset
//   bus_addr[7:0]       : byte address in the UART window (bit 0 ignored)
//   bus_write/bus_read  : 16-bit write / read data
//   bus_ds, bus_we      : data strobe (held until ack) and write enable
//   bus_ack             : one-cycle acknowledge per strobe
//   uart_txd, uart_rxd  : serial out (idle high) / asynchronous serial in
//   irq                 : (rx_not_empty & rx_ie) | (tx_empty & tx_ie)
module uart_slave
  import uart_pkg::*;
#(
  parameter logic [15:0] CLK_DIV_RESET   = 16'd434,
  parameter int          FIFO_DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  bus_addr,
  input  logic [15:0] bus_write,
  output logic [15:0] bus_read,
  input  logic        bus_ds,
  input  logic        bus_we,
  output logic        bus_ack,
  output logic        uart_txd,
  input  logic        uart_rxd,
  output logic        irq
);

  function automatic logic [15:0] sat_div(input logic [15:0] v);
    return (v < MIN_DIV) ? MIN_DIV : v;
  endfunction

  logic [7:0]  reg_addr;
  logic        ds_armed, acc, rd_acc, wr_acc;
  logic [15:0] divisor, status, rd_data;
  logic        rx_ie, tx_ie, overrun, tx_busy;

  logic        tx_push, tx_pop, tx_full, tx_empty;
  logic        rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]  tx_dout, rx_dout;
  logic [FIFO_DEPTH_LOG2:0] tx_count, rx_count;

  assign reg_addr = {bus_addr[7:1], 1'b0};
  // One access per strobe: re-armed only once ds has been sampled low.
  assign acc    = bus_ds & ds_armed;
  assign rd_acc = acc & ~bus_we;
  assign wr_acc = acc & bus_we;

  assign tx_push = wr_acc & (reg_addr == ADDR_DATA);
  assign rx_pop  = rd_acc & (reg_addr == ADDR_DATA);
  assign irq     = (~rx_empty & rx_ie) | (tx_empty & tx_ie);

  always_comb begin
    status = '0;
    status[STAT_RX_NOT_EMPTY] = ~rx_empty;
    status[STAT_RX_FULL]      = rx_full;
    status[STAT_TX_EMPTY]     = tx_empty;
    status[STAT_TX_FULL]      = tx_full;
    status[STAT_TX_BUSY]      = tx_busy;
    status[STAT_OVERRUN]      = overrun;
  end

  always_comb begin
    rd_data = '0;
    case (reg_addr)
      ADDR_DATA:   rd_data = rx_empty ? 16'h0000 : {8'h00, rx_dout};
      ADDR_STATUS: rd_data = status;
      ADDR_BAUD:   rd_data = divisor;
      ADDR_CTRL:   rd_data = {14'b0, tx_ie, rx_ie};
      default:     rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ds_armed <= 1'b1;
      bus_ack  <= 1'b0;
      bus_read <= '0;
      divisor  <= CLK_DIV_RESET;
      rx_ie    <= 1'b0;
      tx_ie    <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      bus_ack <= acc;
      if (!bus_ds)  ds_armed <= 1'b1;
      else if (acc) ds_armed <= 1'b0;
      if (rd_acc) bus_read <= rd_data;
      if (wr_acc) begin
        case (reg_addr)
          ADDR_BAUD: divisor <= sat_div(bus_write);
          ADDR_CTRL: {tx_ie, rx_ie} <= bus_write[1:0];
          default: ;
        endcase
      end
      // A pop in the same cycle makes room, so only a real drop is an overrun.
      if (rx_push && rx_full && !rx_pop)                 overrun <= 1'b1;
      else if (wr_acc && (reg_addr == ADDR_STATUS))      overrun <= 1'b0;
    end
  end

  sync_fifo #(.WIDTH(8), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_tx_fifo (
    .clk(clk), .reset_n(reset_n), .push(tx_push), .din(bus_write[7:0]),
    .pop(tx_pop), .dout(tx_dout), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  // ---------------- TX engine ----------------
  uart_state_e tx_state, tx_state_d;
  logic [15:0] tx_cnt, tx_div_q;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;
  logic        tx_bit_end;

  // tx_div_q is reloaded at every bit boundary so a new divisor waits for one.
  assign tx_bit_end = (tx_cnt == tx_div_q - 16'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tx_state <= S_IDLE;
    else          tx_state <= tx_state_d;
  end

  always_comb begin
    tx_state_d = tx_state;
    case (tx_state)
      S_IDLE:  if (!tx_empty)                    tx_state_d = S_START;
      S_START: if (tx_bit_end)                   tx_state_d = S_DATA;
      S_DATA:  if (tx_bit_end && tx_bit == 3'd7) tx_state_d = S_STOP;
      S_STOP:  if (tx_bit_end)                   tx_state_d = S_IDLE;
      default:                                   tx_state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_pop   = (tx_state == S_IDLE) && !tx_empty;
    tx_busy  = (tx_state != S_IDLE);
    uart_txd = 1'b1;
    case (tx_state)
      S_START: uart_txd = 1'b0;
      S_DATA:  uart_txd = tx_shift[0];
      default: uart_txd = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_cnt   <= '0;
      tx_div_q <= CLK_DIV_RESET;
      tx_bit   <= '0;
    end else if (tx_state == S_IDLE || tx_bit_end) begin
      tx_cnt   <= '0;
      tx_div_q <= divisor;
      if (tx_state == S_DATA && tx_bit_end) tx_bit <= tx_bit + 3'd1;
      else if (tx_state == S_IDLE)          tx_bit <= '0;
    end else begin
      tx_cnt <= tx_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_pop)                              tx_shift <= tx_dout;
    else if (tx_state == S_DATA && tx_bit_end) tx_shift <= {1'b0, tx_shift[7:1]};
  end

  // ---------------- RX engine ----------------
  uart_state_e rx_state, rx_state_d;
  logic [1:0]  rx_sync;
  logic        rx_s, rx_sample;
  logic [15:0] rx_cnt, rx_div_q;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;

  assign rx_s = rx_sync[1];

  // Start bit is checked half a bit in; later samples land mid-bit.
  always_comb begin
    rx_sample = 1'b0;
    case (rx_state)
      S_START:        rx_sample = (rx_cnt == (rx_div_q >> 1) - 16'd1);
      S_DATA, S_STOP: rx_sample = (rx_cnt == rx_div_q - 16'd1);
      default:        rx_sample = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_sync  <= 2'b11;
      rx_state <= S_IDLE;
    end else begin
      rx_sync  <= {rx_sync[0], uart_rxd};
      rx_state <= rx_state_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state;
    case (rx_state)
      S_IDLE:  if (!rx_s)                       rx_state_d = S_START;
      S_START: if (rx_sample)                   rx_state_d = rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (rx_sample && rx_bit == 3'd7) rx_state_d = S_STOP;
      S_STOP:  if (rx_sample)                   rx_state_d = S_IDLE;
      default:                                  rx_state_d = S_IDLE;
    endcase
  end

  // A low stop bit is a framing error: the byte is simply not pushed.
  always_comb begin
    rx_push = (rx_state == S_STOP) && rx_sample && rx_s;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_cnt   <= '0;
      rx_div_q <= CLK_DIV_RESET;
      rx_bit   <= '0;
    end else if (rx_state == S_IDLE || rx_sample) begin
      rx_cnt   <= '0;
      rx_div_q <= divisor;
      if (rx_state == S_DATA && rx_sample) rx_bit <= rx_bit + 3'd1;
      else if (rx_state == S_IDLE)         rx_bit <= '0;
    end else begin
      rx_cnt <= rx_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_state == S_DATA && rx_sample) rx_shift <= {rx_s, rx_shift[7:1]};
  end

  sync_fifo #(.WIDTH(8), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_rx_fifo (
    .clk(clk), .reset_n(reset_n), .push(rx_push), .din(rx_shift),
    .pop(rx_pop), .dout(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  logic unused_bits;
  assign unused_bits = ^{bus_addr[0], tx_count, rx_count};

endmodule
